// File: rtl/booth4_pkg.sv
// booth4_pkg: shared types and digit recoding
// for the radix-4 Booth multiplier.
package booth4_pkg;

  localparam int INV  = 2;
  localparam int SEL2 = 1;
  localparam int SEL1 = 0;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Map a 3-bit multiplier window to {inv, sel2, sel1}
  function automatic logic [2:0] booth4_recode(
    input logic [2:0] w
  );
    logic [2:0] c;
    c = 3'b000;
    case (w)
      3'd1, 3'd2: c = 3'b001;
      3'd3:       c = 3'b010;
      3'd4:       c = 3'b110;
      3'd5, 3'd6: c = 3'b101;
      default:    c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/booth4_pp_gen.sv
// booth4_pp_gen: partial product for one
// Booth digit; negation is ~x plus carry-in.
module booth4_pp_gen
  import booth4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]        mcand,
  input  logic [2:0]              code,
  output logic signed [WIDTH+1:0] pp
);

  logic [WIDTH+1:0] mag;
  logic [WIDTH+1:0] ones;
  logic [WIDTH+1:0] cin;

  // pick 0, m or 2m, sign-extended to WIDTH+2
  always_comb begin
    mag = '0;
    unique case (1'b1)
      code[SEL2]: mag = {mcand[WIDTH-1], mcand, 1'b0};
      code[SEL1]: mag = {{2{mcand[WIDTH-1]}}, mcand};
      default:    mag = '0;
    endcase
  end

  assign ones = code[INV] ? ~mag : mag;
  assign cin  = {{(WIDTH+1){1'b0}}, code[INV]};
  assign pp   = signed'(ones + cin);

endmodule

// File: rtl/booth4_seq_mult.sv
// booth4_seq_mult: sequential signed radix-4
// Booth multiplier, one digit per clock.
module booth4_seq_mult
  import booth4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int PW = 2 * WIDTH;
  localparam int ND = WIDTH / 2;
  localparam int CW = (ND > 2) ? $clog2(ND) : 1;
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  state_t                  state;
  logic [WIDTH-1:0]        mcand;
  logic [WIDTH:0]          mreg;
  logic [PW-1:0]           acc;
  logic [CW-1:0]           count;
  logic [2:0]              code;
  logic signed [WIDTH+1:0] pp;
  logic [PW-1:0]           pp_ext;
  logic [PW-1:0]           acc_next;

  assign code = booth4_recode(mreg[2:0]);

  booth4_pp_gen #(
    .WIDTH(WIDTH)
  ) u_pp (
    .mcand(mcand),
    .code (code),
    .pp   (pp)
  );

  assign pp_ext = {{(PW-WIDTH-2){pp[WIDTH+1]}}, pp};

  // weight digit i by 4^i; wraps mod 2^PW
  assign acc_next = acc + (pp_ext << {count, 1'b0});

  // control FSM with datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      acc   <= '0;
      mreg  <= '0;
      mcand <= '0;
      count <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            mreg  <= {b, 1'b0};
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          mreg  <= {{2{mreg[WIDTH]}}, mreg[WIDTH:2]};
          count <= count + 1'b1;
          if (count == LAST) begin
            p     <= acc_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
